// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the i/d cache to RAM arbiter
// Contents: ramstate_t (RAM handshake state), word_t, arb_state_t (arbiter FSM state).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_stats.sv
// rtl/memory_arbiter_stats.sv - performance counters for the memory arbiter
// Ports: clk, rst (async, active-high); igrant/dgrant pulse once per completed
// icache/dcache access; stall is high for each cycle a requester is kept waiting;
// igrants/dgrants/stalls are free-running 32-bit wrap-around counts.
module memory_arbiter_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        igrant,
    input  logic        dgrant,
    input  logic        stall,
    output logic [31:0] igrants,
    output logic [31:0] dgrants,
    output logic [31:0] stalls
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            igrants <= '0;
            dgrants <= '0;
            stalls  <= '0;
        end else begin
            if (igrant) igrants <= igrants + 32'd1;
            if (dgrant) dgrants <= dgrants + 32'd1;
            if (stall)  stalls  <= stalls + 32'd1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - dcache-priority arbiter onto a single-port RAM with icache starvation limit
// Ports: CLK, nRST (async, active-high); icache side iREN/iaddr -> iwait/iload;
// dcache side dREN/dWEN/daddr/dstore -> dwait/dload; RAM side ramREN/ramWEN/ramaddr/
// ramstore -> ramload/ramstate; ram_err sticky error flag; stat_* perf counters.
// Macro MEMORY_ARBITER_STATS_EN: when defined the stat_* counters are built,
// otherwise they read as 0.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err,
    output logic [31:0]       stat_igrants,
    output logic [31:0]       stat_dgrants,
    output logic [31:0]       stat_stalls
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_t state;
    logic [SW-1:0] streak;
    ramstate_t rs;
    logic dreq;
    logic i_done;
    logic d_done;

    assign rs     = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;
    assign i_done = (state == IGNT) && iREN && (rs == ACCESS);
    assign d_done = (state == DGNT) && dreq && (rs == ACCESS);

    // RAM controls and completion are decoded from the registered state so that a
    // dropped request or an asynchronous reset removes the enables in the same cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = !i_done;
            end
            DGNT: begin
                // a write wins over a read when both are raised
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = !d_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state   <= IDLE;
            streak  <= '0;
            ram_err <= 1'b0;
        end else begin
            if (rs == ERROR) ram_err <= 1'b1;
            case (state)
                IDLE: begin
                    // icache is forced through once dcache has won LIMIT times in a row
                    if (dreq && !(iREN && streak == LIMIT)) begin
                        state <= DGNT;
                        if (!iREN)
                            streak <= '0;
                        else if (streak != LIMIT)
                            streak <= streak + 1'b1;
                    end else if (iREN) begin
                        state  <= IGNT;
                        streak <= '0;
                    end else begin
                        streak <= '0;
                    end
                end
                // ERROR/BUSY/FREE keep the grant so the access is retried
                IGNT: if (!iREN || i_done) state <= IDLE;
                DGNT: if (!dreq || d_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMORY_ARBITER_STATS_EN
    logic stall;
    assign stall = (iREN && iwait) || (dreq && dwait);

    memory_arbiter_stats u_stats (
        .clk     (CLK),
        .rst     (nRST),
        .igrant  (i_done),
        .dgrant  (d_done),
        .stall   (stall),
        .igrants (stat_igrants),
        .dgrants (stat_dgrants),
        .stalls  (stat_stalls)
    );
`else
    assign stat_igrants = '0;
    assign stat_dgrants = '0;
    assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
module tb_memory_arbiter;

    logic        clk;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;
    logic [31:0] stat_igrants;
    logic [31:0] stat_dgrants;
    logic [31:0] stat_stalls;

    int tests = 0;
    int fails = 0;

    memory_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
        .CLK          (clk),
        .nRST         (nRST),
        .iREN         (iREN),
        .iaddr        (iaddr),
        .iwait        (iwait),
        .iload        (iload),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .dwait        (dwait),
        .dload        (dload),
        .ramREN       (ramREN),
        .ramWEN       (ramWEN),
        .ramaddr      (ramaddr),
        .ramstore     (ramstore),
        .ramload      (ramload),
        .ramstate     (ramstate),
        .ram_err      (ram_err),
        .stat_igrants (stat_igrants),
        .stat_dgrants (stat_dgrants),
        .stat_stalls  (stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iren;
        logic [31:0] ia;
        logic        dren;
        logic        dwen;
        logic [31:0] da;
        logic [31:0] ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    int          n;
    logic [9:0]  order;
    int          dzero;

    initial begin
        // ramstate: FREE=0 BUSY=1 ACCESS=2 ERROR=3
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,    2'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0,    32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h80,  32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[3]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h80,  32'h0,    2'd1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h80,  32'h0,    32'h0,        32'h0};
        vecs[4]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h80,  32'h0,    2'd2, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80,  32'h0,    32'h0,        32'hCAFE0001};
        vecs[5]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[6]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,    2'd2, 32'h11112222, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44,  32'h0,    32'h11112222, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'h1234, 2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'h1234, 2'd2, 32'h5555,     1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h1234, 32'h0,        32'h5555};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h200, 32'h0,    2'd1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,    32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h200, 32'h0,    2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0};

        // reset state
        nRST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ren", {31'b0, ramREN}, 32'd0);
        chk("rst_wen", {31'b0, ramWEN}, 32'd0);
        chk("rst_err", {31'b0, ram_err}, 32'd0);
        chk("rst_stat_i", stat_igrants, 32'd0);
        chk("rst_stat_d", stat_dgrants, 32'd0);
        chk("rst_stat_s", stat_stalls, 32'd0);
        @(negedge clk);
        nRST = 1'b0;

        // single-access latency, priority, write precedence, request drop
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].iren, vecs[i].ia, vecs[i].dren, vecs[i].dwen,
                  vecs[i].da, vecs[i].ds, vecs[i].rs, vecs[i].rl);
            #2;
            chk($sformatf("row%0d_iwait", i), {31'b0, iwait}, {31'b0, vecs[i].e_iwait});
            chk($sformatf("row%0d_dwait", i), {31'b0, dwait}, {31'b0, vecs[i].e_dwait});
            chk($sformatf("row%0d_ren", i), {31'b0, ramREN}, {31'b0, vecs[i].e_ren});
            chk($sformatf("row%0d_wen", i), {31'b0, ramWEN}, {31'b0, vecs[i].e_wen});
            chk($sformatf("row%0d_addr", i), ramaddr, vecs[i].e_addr);
            chk($sformatf("row%0d_store", i), ramstore, vecs[i].e_store);
            chk($sformatf("row%0d_iload", i), iload, vecs[i].e_iload);
            chk($sformatf("row%0d_dload", i), dload, vecs[i].e_dload);
        end

        // starvation limiter: d d d d i, then streak restarts: d d d d i
        n = 0;
        order = '0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            drive(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0, 2'd2, 32'h0);
            #2;
            if (!dwait) begin
                order[n] = 1'b0;
                n++;
            end else if (!iwait) begin
                order[n] = 1'b1;
                n++;
            end
        end
        chk("starve_count", n, 32'd10);
        chk("starve_order", {22'b0, order}, 32'h210);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);

        // ERROR for one cycle then ACCESS: sticky flag, single completion
        dzero = 0;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd0, 32'h0);
        #2;
        chk("err_before", {31'b0, ram_err}, 32'd0);
        if (!dwait) dzero++;
        @(negedge clk);
        ramstate = 2'd3;
        #2;
        chk("err_retry_ren", {31'b0, ramREN}, 32'd1);
        chk("err_retry_dwait", {31'b0, dwait}, 32'd1);
        if (!dwait) dzero++;
        @(negedge clk);
        ramstate = 2'd2;
        ramload = 32'h77;
        #2;
        chk("err_flag_set", {31'b0, ram_err}, 32'd1);
        chk("err_done_dload", dload, 32'h77);
        if (!dwait) dzero++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
            #2;
            if (!dwait) dzero++;
        end
        chk("err_sticky", {31'b0, ram_err}, 32'd1);
        chk("err_one_completion", dzero, 32'd1);

        // reset in the middle of a BUSY dcache access
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        ramstate = 2'd1;
        #2;
        chk("mid_ren_before", {31'b0, ramREN}, 32'd1);
        #1;
        nRST = 1'b1;
        #1;
        chk("mid_ren_abort", {31'b0, ramREN}, 32'd0);
        chk("mid_wen_abort", {31'b0, ramWEN}, 32'd0);
        chk("mid_dwait_abort", {31'b0, dwait}, 32'd1);
        chk("mid_addr_abort", ramaddr, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        nRST = 1'b0;
        #2;
        chk("mid_err_cleared", {31'b0, ram_err}, 32'd0);
        chk("mid_stat_i", stat_igrants, 32'd0);
        chk("mid_stat_d", stat_dgrants, 32'd0);
        chk("mid_stat_s", stat_stalls, 32'd0);
        // FSM is back in IDLE: a fresh icache request needs arbitrate + access
        @(negedge clk);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'hABCD);
        #2;
        chk("post_rst_idle_iwait", {31'b0, iwait}, 32'd1);
        chk("post_rst_idle_ren", {31'b0, ramREN}, 32'd0);
        @(negedge clk);
        #2;
        chk("post_rst_iwait", {31'b0, iwait}, 32'd0);
        chk("post_rst_iload", iload, 32'hABCD);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
